diff_scheduler: RTL and testbench
=================================

DIFF_SCHEDULER -- requirements
Module: diff_scheduler

Interface
REQ-001 SHALL have parameter SCAN_W, default 4: XOR bits examined per SCAN cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 2: bit i means requester i presents an operand pair.
REQ-005 SHALL have port a0, input, 32: requester 0 operand A.
REQ-006 SHALL have port b0, input, 32: requester 0 operand B.
REQ-007 SHALL have port a1, input, 32: requester 1 operand A.
REQ-008 SHALL have port b1, input, 32: requester 1 operand B.
REQ-009 SHALL have port req_ready, output, 2: bit i means requester i is accepted this cycle when req_valid[i] is also high.
REQ-010 SHALL have port rsp_valid, output, 1: result available.
REQ-011 SHALL have port rsp_ready, input, 1: consumer takes the result.
REQ-012 SHALL have port rsp_id, output, 1: index of the requester that owns the result.
REQ-013 SHALL have port rsp_out, output, 32: index of the lowest differing bit of A and B, zero-extended.
REQ-014 SHALL have port rsp_eq, output, 1: A equals B.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-016 SHALL implement a state machine with states IDLE, SCAN and DONE.
REQ-017 In IDLE, SHALL drive req_ready combinationally to one-hot grant ANDed with req_valid; req_ready SHALL be 2'b00 in SCAN and DONE.
REQ-018 SHALL arbitrate round-robin: if one requester is valid, grant it; if both are valid, grant the requester not granted last; the last-granted pointer resets to 1, so requester 0 wins first.
REQ-019 On acceptance (edge at cycle T), SHALL latch x = A^B and owner id, clear scan index k, and enter SCAN; the pointer SHALL update at acceptance.
REQ-020 In SCAN, each cycle SHALL examine slice x[SCAN_W*k +: SCAN_W].
- Slice nonzero: result = SCAN_W*k + position of lowest set bit in the slice; go to DONE.
- Slice zero and not last: k increments.
REQ-021 If the last slice (k = 32/SCAN_W - 1) is zero, SHALL set result 0 and eq 1, and go to DONE.
REQ-022 Latency: rsp_valid SHALL first be high at cycle T+2+k_found, where k_found is the index of the first nonzero slice, or the last index if A equals B; for SCAN_W=4 the worst case is T+9.
REQ-023 In DONE, rsp_valid, rsp_id, rsp_out and rsp_eq SHALL be registered and held stable until rsp_valid & rsp_ready; then the block SHALL return to IDLE.
REQ-024 SHALL not accept a request in the same cycle as a response handshake (one-cycle bubble minimum).
REQ-025 Outside DONE, rsp_valid SHALL be 0; rsp_out, rsp_id and rsp_eq keep their last values.
REQ-026 Requesters SHALL hold valid and operands stable until accepted; the block SHALL sample operands only at acceptance, so later operand changes do not affect the result.
REQ-027 rsp_out SHALL never exceed 31; bits [31:5] SHALL always be 0.

Reset
REQ-028 While rst is 0, SHALL force: state IDLE, rsp_valid 0, rsp_out 0, rsp_id 0, rsp_eq 0, busy 0, k 0, pointer 1.
REQ-029 Reset asserted mid-SCAN or mid-DONE SHALL abort the operation with no response emitted.
REQ-030 After reset deassertion, the first cycle SHALL be IDLE, with req_ready driven per REQ-017.

Verification
REQ-031 SHALL cover: a0=0x000000F0, b0=0, SCAN_W=4, accept at T -> rsp_valid at T+3, rsp_out=4, rsp_eq=0, rsp_id=0.
REQ-032 SHALL cover: a1=b1=0x12345678 -> rsp_valid at T+9, rsp_out=0, rsp_eq=1, rsp_id=1.
REQ-033 SHALL cover: a0=0x80000000, b0=0 -> rsp_valid at T+9, rsp_out=31, rsp_eq=0.
REQ-034 SHALL cover: both req_valid held high from reset with rsp_ready=1 -> grants in order 0,1,0,1; req_ready never 2'b11.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles in DONE -> rsp_* stable, busy=1, req_ready=2'b00 throughout.
REQ-036 SHALL cover: rst pulsed low during SCAN -> outputs at reset values immediately, no rsp_valid; with both requesters valid afterwards, the next grant goes to requester 0.

Source files
------------

// File: rtl/diff_scheduler.sv
// Two-requester round-robin scheduler that finds the lowest differing bit of A and B
// by scanning A^B in SCAN_W-bit slices, one slice per cycle.
module diff_scheduler #(
  parameter int SCAN_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_out,
  output logic        rsp_eq,
  output logic        busy
);
  localparam int NSLICE = 32 / SCAN_W;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]       x;
  logic [KW-1:0]     k;
  logic              own, last;
  logic [4:0]        res;
  logic              eq_q, id_q;
  logic              gnt, accept;
  logic [SCAN_W-1:0] slice;
  logic [4:0]        base, pos;
  logic              hit, at_last;

  // Alternate on contention; a lone requester always wins.
  always_comb begin
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = ~last;
    endcase
  end

  always_comb begin
    slice = '0;
    base  = '0;
    for (int i = 0; i < NSLICE; i++)
      if (k == KW'(i)) begin
        slice = x[i*SCAN_W +: SCAN_W];
        base  = 5'(i * SCAN_W);
      end
  end

  // Descending loop so the lowest set bit is the final assignment.
  always_comb begin
    pos = '0;
    for (int j = SCAN_W - 1; j >= 0; j--)
      if (slice[j]) pos = 5'(j);
  end

  assign hit     = |slice;
  assign at_last = (k == KLAST);
  assign accept  = |req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (hit || at_last) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) req_ready = req_valid & (gnt ? 2'b10 : 2'b01);
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x    <= '0;
      k    <= '0;
      own  <= 1'b0;
      last <= 1'b1;
      res  <= '0;
      eq_q <= 1'b0;
      id_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x    <= gnt ? (a1 ^ b1) : (a0 ^ b0);
          own  <= gnt;
          last <= gnt;
          k    <= '0;
        end
        SCAN: begin
          if (hit) begin
            res  <= base + pos;
            eq_q <= 1'b0;
            id_q <= own;
          end else if (at_last) begin
            res  <= '0;
            eq_q <= 1'b1;
            id_q <= own;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_out = {27'b0, res};
  assign rsp_eq  = eq_q;
  assign rsp_id  = id_q;
endmodule

// File: tb/tb_diff_scheduler.sv
// Directed bench for diff_scheduler (SCAN_W=4): latency, result, arbitration,
// back-pressure and mid-scan reset.
module tb_diff_scheduler;
  logic        clk, rst, rsp_ready;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] a0, b0, a1, b1, rsp_out;
  logic        rsp_valid, rsp_id, rsp_eq, busy;
  int          total, bad;

  diff_scheduler #(.SCAN_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_eq(rsp_eq), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts negedges until rsp_valid; n is the offset from the acceptance cycle.
  task automatic wait_rsp(inout int n);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  // Called at a negedge with the block idle and rsp_ready=1.
  task automatic run_op(input string tag, input logic [1:0] vld, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] erdy, input int elat,
                        input logic [31:0] eout, input logic eeq, input logic eid);
    int n;
    req_valid = vld;
    if (vld[0]) begin a0 = a; b0 = b; end
    else begin a1 = a; b1 = b; end
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(erdy));
    @(posedge clk); #1;
    req_valid = 2'b00;
    a0 = ~a0; a1 = a1 ^ 32'h0F0F_0F0F;
    n = 0;
    wait_rsp(n);
    chk({tag, "_lat"}, 32'(n), 32'(elat));
    chk({tag, "_out"}, rsp_out, eout);
    chk({tag, "_eq"}, 32'(rsp_eq), 32'(eeq));
    chk({tag, "_id"}, 32'(rsp_id), 32'(eid));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_after_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_after_busy"}, 32'(busy), 32'd0);
    chk({tag, "_after_out"}, rsp_out, eout);
  endtask

  initial begin
    int n, w;
    logic both11;
    total = 0; bad = 0;
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_out", rsp_out, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_eq", 32'(rsp_eq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("f0",   2'b01, 32'h0000_00F0, 32'h0, 2'b01, 3, 32'd4,  1'b0, 1'b0);
    run_op("eq",   2'b10, 32'h1234_5678, 32'h1234_5678, 2'b10, 9, 32'd0, 1'b1, 1'b1);
    run_op("msb",  2'b01, 32'h8000_0000, 32'h0, 2'b01, 9, 32'd31, 1'b0, 1'b0);
    run_op("lsb",  2'b10, 32'h0000_0001, 32'h0, 2'b10, 2, 32'd0,  1'b0, 1'b1);

    // Back-pressure: result held while rsp_ready is low, no grants meanwhile.
    req_valid = 2'b01; a0 = 32'h0001_0000; b0 = 32'h0; rsp_ready = 1'b0;
    #1 chk("st_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b11; a1 = 32'h8000_0000; b1 = 32'h0;
    n = 0;
    wait_rsp(n);
    chk("st_lat", 32'(n), 32'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("st_vld", 32'(rsp_valid), 32'd1);
      chk("st_out", rsp_out, 32'd16);
      chk("st_id", 32'(rsp_id), 32'd0);
      chk("st_eq", 32'(rsp_eq), 32'd0);
      chk("st_busy", 32'(busy), 32'd1);
      chk("st_noready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("hs_noready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("hs_after_vld", 32'(rsp_valid), 32'd0);
    chk("hs_next_grant", 32'(req_ready), 32'h2);

    // Requester 1 accepted here; reset lands two cycles into its scan.
    @(posedge clk);
    repeat (2) @(negedge clk);
    chk("scan_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_vld", 32'(rsp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_out", rsp_out, 32'd0);
    chk("mid_id", 32'(rsp_id), 32'd0);
    chk("mid_eq", 32'(rsp_eq), 32'd0);
    a0 = 32'h1; b0 = 32'h0; a1 = 32'h1; b1 = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Both requesters held valid: grants must alternate starting at 0.
    both11 = 1'b0;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (req_ready == 2'b00 && w < 30) begin
        @(negedge clk); #1;
        w++;
        if (req_ready == 2'b11) both11 = 1'b1;
      end
      if (req_ready == 2'b11) both11 = 1'b1;
      chk("rr_grant", 32'(req_ready), g[0] ? 32'h2 : 32'h1);
      @(posedge clk);
      @(negedge clk); #1;
      if (req_ready == 2'b11) both11 = 1'b1;
    end
    chk("rr_never11", 32'(both11), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
